// File: rtl/aeolus_multicycle_sequencer_pkg.sv
// Shared definitions for the Aeolus multi-cycle sequencer: opcode numbering,
// FSM state encoding and the opcode classes that write the accumulator.
// Optional feature macro used by the sequencer: AEOLUS_SEQ_STEP_EN.
package aeolus_pkg;

    // Default datapath widths
    localparam int SEQ_OPCODE_WIDTH = 4;
    localparam int SEQ_CTRL_WIDTH   = 16;
    localparam int SEQ_COUNT_WIDTH  = 16;

    // Instruction ROM opcodes; the one-hot strobe index equals the opcode value
    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDO  = 4'd2;
    localparam logic [3:0] OP_LDSA = 4'd3;
    localparam logic [3:0] OP_LDSB = 4'd4;
    localparam logic [3:0] OP_LSH  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_SNZA = 4'd8;
    localparam logic [3:0] OP_SNZS = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_INV  = 4'd15;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC     = 3'd1;
    localparam logic [2:0] ST_DECODE_ENC    = 3'd2;
    localparam logic [2:0] ST_EXECUTE_ENC   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK_ENC = 3'd4;
    localparam logic [2:0] ST_HALT_ENC      = 3'd5;
    localparam logic [2:0] ST_STEP_WAIT_ENC = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE_ENC,
        S_FETCH     = ST_FETCH_ENC,
        S_DECODE    = ST_DECODE_ENC,
        S_EXECUTE   = ST_EXECUTE_ENC,
        S_WRITEBACK = ST_WRITEBACK_ENC,
        S_HALT      = ST_HALT_ENC,
        S_STEP_WAIT = ST_STEP_WAIT_ENC
    } seq_state_e;

    // Opcodes that unconditionally write the accumulator (CLR and the ALU group)
    localparam logic [15:0] ACC_WRITE_MASK = (16'd1 << OP_CLR) | (16'd1 << OP_ADD) |
                                             (16'd1 << OP_SUB) | (16'd1 << OP_AND) |
                                             (16'd1 << OP_OR)  | (16'd1 << OP_XOR) |
                                             (16'd1 << OP_INV);

    // Conditional opcodes that write the accumulator only when the shift flag is set
    localparam logic [15:0] COND_WRITE_MASK = (16'd1 << OP_SNZA) | (16'd1 << OP_SNZS);

    // Opcodes that never touch the accumulator (loads and shifts)
    localparam logic [15:0] NO_ACC_MASK = (16'd1 << OP_LDA)  | (16'd1 << OP_LDB)  |
                                          (16'd1 << OP_LDO)  | (16'd1 << OP_LDSA) |
                                          (16'd1 << OP_LDSB) | (16'd1 << OP_LSH)  |
                                          (16'd1 << OP_RSH);

endpackage

// File: rtl/aeolus_multicycle_sequencer_if.sv
// Bus between the sequencer and the rest of the Aeolus datapath: run/step
// control, ROM opcode and flags in, datapath strobes and status out.
interface aeolus_multicycle_sequencer_if #(
    parameter int OPCODE_WIDTH = aeolus_pkg::SEQ_OPCODE_WIDTH,
    parameter int CTRL_WIDTH   = aeolus_pkg::SEQ_CTRL_WIDTH,
    parameter int COUNT_WIDTH  = aeolus_pkg::SEQ_COUNT_WIDTH
);
    logic                    run;
    logic                    step;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    sf;
    logic                    pc_last;
    logic                    pc_en;
    logic                    ir_load;
    logic [CTRL_WIDTH-1:0]   ctrl;
    logic                    acc_en;
    logic                    cond_taken;
    logic                    busy;
    logic                    retired;
    logic [COUNT_WIDTH-1:0]  instr_count;

    // Datapath / board side: drives control and ROM data, observes strobes
    modport master (
        output run, step, opcode, sf, pc_last,
        input  pc_en, ir_load, ctrl, acc_en, cond_taken, busy, retired, instr_count
    );

    // Sequencer side
    modport slave (
        input  run, step, opcode, sf, pc_last,
        output pc_en, ir_load, ctrl, acc_en, cond_taken, busy, retired, instr_count
    );

endinterface

// File: rtl/aeolus_multicycle_sequencer_decoder.sv
// Combinational opcode to one-hot strobe decoder, shared with the
// single-cycle Aeolus top.
module aeolus_opcode_decoder
    import aeolus_pkg::*;
#(
    parameter int OPCODE_WIDTH = SEQ_OPCODE_WIDTH,
    parameter int CTRL_WIDTH   = SEQ_CTRL_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic [CTRL_WIDTH-1:0]   o_onehot
);

    // Exactly one bit set, at the index equal to the opcode value
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (i_opcode == OPCODE_WIDTH'(i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aeolus_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the Aeolus
// CPU. All outputs are registered from the next state so each strobe lines up
// with the state it belongs to.
// Optional feature macro: AEOLUS_SEQ_STEP_EN (single-step wait after each
// instruction, released by the step input).
module aeolus_multicycle_sequencer
    import aeolus_pkg::*;
#(
    parameter int OPCODE_WIDTH = SEQ_OPCODE_WIDTH,
    parameter int CTRL_WIDTH   = SEQ_CTRL_WIDTH,
    parameter int COUNT_WIDTH  = SEQ_COUNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    aeolus_multicycle_sequencer_if.slave  bus
);

    seq_state_e              r_state;
    seq_state_e              w_nextState;
    logic [OPCODE_WIDTH-1:0] r_ir;
    logic [CTRL_WIDTH-1:0]   w_decoded;
    logic [CTRL_WIDTH-1:0]   w_accMask;
    logic [CTRL_WIDTH-1:0]   w_condMask;
    logic                    w_isAccOp;
    logic                    w_isCondOp;

    logic                    r_irLoad;
    logic [CTRL_WIDTH-1:0]   r_ctrl;
    logic                    r_accEn;
    logic                    r_condTaken;
    logic                    r_busy;
    logic                    r_retired;
    logic [COUNT_WIDTH-1:0]  r_instrCount;

    logic                    w_nextIrLoad;
    logic [CTRL_WIDTH-1:0]   w_nextCtrl;
    logic                    w_nextAccEn;
    logic                    w_nextCondTaken;
    logic                    w_nextBusy;
    logic                    w_nextRetired;

    aeolus_opcode_decoder #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .CTRL_WIDTH   (CTRL_WIDTH)
    ) u_decoder (
        .i_opcode (r_ir),
        .o_onehot (w_decoded)
    );

    assign w_accMask  = CTRL_WIDTH'(ACC_WRITE_MASK);
    assign w_condMask = CTRL_WIDTH'(COND_WRITE_MASK);
    assign w_isAccOp  = |(w_decoded & w_accMask);
    assign w_isCondOp = |(w_decoded & w_condMask);

`ifndef AEOLUS_SEQ_STEP_EN
    logic w_stepUnused;
    assign w_stepUnused = bus.step;
`endif

    // Next-state logic: run is only looked at in IDLE and WRITEBACK (and STEP_WAIT)
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH:     w_nextState = S_DECODE;
            S_DECODE:    w_nextState = S_EXECUTE;
            S_EXECUTE:   w_nextState = S_WRITEBACK;
            S_WRITEBACK: begin
                if (bus.pc_last) begin
                    w_nextState = S_HALT;
`ifdef AEOLUS_SEQ_STEP_EN
                end else begin
                    w_nextState = S_STEP_WAIT;
                end
`else
                end else if (!bus.run) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_nextState = S_FETCH;
                end
`endif
            end
            S_HALT:      w_nextState = S_HALT;
`ifdef AEOLUS_SEQ_STEP_EN
            S_STEP_WAIT: begin
                if (!bus.run) begin
                    w_nextState = S_IDLE;
                end else if (bus.step) begin
                    w_nextState = S_FETCH;
                end
            end
`endif
            default:     w_nextState = S_IDLE;
        endcase
    end

    // Moore output decode from the state about to be entered. The shift flag for
    // SNZA/SNZS is taken at the edge that starts EXECUTE, so the accumulator
    // enable and cond_taken are stable for the whole EXECUTE cycle.
    always_comb begin
        w_nextIrLoad    = 1'b0;
        w_nextCtrl      = '0;
        w_nextAccEn     = 1'b0;
        w_nextCondTaken = 1'b0;
        w_nextBusy      = 1'b0;
        w_nextRetired   = 1'b0;
        case (w_nextState)
            S_FETCH: begin
                w_nextIrLoad = 1'b1;
                w_nextBusy   = 1'b1;
            end
            S_DECODE: begin
                w_nextBusy = 1'b1;
            end
            S_EXECUTE: begin
                w_nextBusy      = 1'b1;
                w_nextCtrl      = w_decoded;
                w_nextCondTaken = w_isCondOp & bus.sf;
                w_nextAccEn     = w_isAccOp | (w_isCondOp & bus.sf);
            end
            S_WRITEBACK: begin
                w_nextBusy    = 1'b1;
                w_nextRetired = 1'b1;
            end
            S_STEP_WAIT: begin
                w_nextBusy = 1'b1;
            end
            default: begin
                w_nextBusy = 1'b0;
            end
        endcase
    end

    // State, instruction register, registered strobes and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_irLoad     <= 1'b0;
            r_ctrl       <= '0;
            r_accEn      <= 1'b0;
            r_condTaken  <= 1'b0;
            r_busy       <= 1'b0;
            r_retired    <= 1'b0;
            r_instrCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_irLoad    <= w_nextIrLoad;
            r_ctrl      <= w_nextCtrl;
            r_accEn     <= w_nextAccEn;
            r_condTaken <= w_nextCondTaken;
            r_busy      <= w_nextBusy;
            r_retired   <= w_nextRetired;
            if (r_state == S_FETCH) begin
                r_ir <= bus.opcode;
            end
            if (w_nextRetired) begin
                r_instrCount <= r_instrCount + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.ir_load     = r_irLoad;
    assign bus.ctrl        = r_ctrl;
    assign bus.acc_en      = r_accEn;
    assign bus.cond_taken  = r_condTaken;
    assign bus.busy        = r_busy;
    assign bus.retired     = r_retired;
    assign bus.pc_en       = r_retired;
    assign bus.instr_count = r_instrCount;

endmodule
